// File: rtl/rx_cmd_decoder_pkg.sv
// Shared definitions for the rx command decoder.
//  - Controller opcode values (mirrors the values used by the control FSM).
//  - Decoder FSM state encoding (3-bit binary).
//  - Opcode classification helper: unknown / no payload / two payload bytes.
package rx_cmd_decoder_pkg;

  localparam logic [7:0] cmd_set_register    = 8'h10;
  localparam logic [7:0] cmd_rw_adconf       = 8'h11;
  localparam logic [7:0] cmd_toggle_mcp      = 8'h20;
  localparam logic [7:0] cmd_toggle_read_ccd = 8'h21;
  localparam logic [7:0] cmd_open_shutter    = 8'h22;
  localparam logic [7:0] cmd_close_shutter   = 8'h23;
  localparam logic [7:0] cmd_reset           = 8'h2F;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH_OP  = 3'd1,
    ST_DECODE    = 3'd2,
    ST_WAIT_MSB  = 3'd3,
    ST_FETCH_MSB = 3'd4,
    ST_WAIT_LSB  = 3'd5,
    ST_FETCH_LSB = 3'd6,
    ST_OUT       = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    OP_UNKNOWN     = 2'd0,
    OP_NO_PAYLOAD  = 2'd1,
    OP_TWO_PAYLOAD = 2'd2
  } op_class_t;

  function automatic op_class_t classify_op(input logic [7:0] op);
    op_class_t cls;
    case (op)
      cmd_set_register,
      cmd_rw_adconf:       cls = OP_TWO_PAYLOAD;
      cmd_toggle_mcp,
      cmd_toggle_read_ccd,
      cmd_open_shutter,
      cmd_close_shutter,
      cmd_reset:           cls = OP_NO_PAYLOAD;
      default:             cls = OP_UNKNOWN;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/rx_cmd_decoder_sat_counter.sv
// 8-bit saturating event counter.
// Ports:
//  clk   in   system clock
//  rst   in   asynchronous active-high reset, clears count
//  inc   in   count one event this cycle
//  count out  8-bit count, holds at 8'hFF
module rx_cmd_decoder_sat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [7:0] count
);

  logic [7:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= 8'h00;
    end else if (inc && (count_reg != 8'hFF)) begin
      count_reg <= count_reg + 8'h01;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/rx_cmd_decoder.sv
// Frames host bytes popped from the rx fifo into commands (opcode + 0 or 2
// payload bytes) and presents them on a valid/ready interface. Unknown opcodes
// are dropped; partial frames are discarded after an inter-byte timeout.
// Ports:
//  clk, rst                 clock, asynchronous active-high reset
//  fifo_rempty/fifo_rdata   rx fifo status and head byte
//  fifo_rinc                pop strobe (combinational from state)
//  ft_busy                  inhibits popping while high
//  cmd_valid/cmd_ready      command handshake
//  cmd_code/cmd_payload     opcode and {msb, lsb} payload
//  err_unknown/err_timeout  1-cycle error pulses
//  err_count                saturating count of both error kinds
module rx_cmd_decoder
  import rx_cmd_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CNT_W          = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_rempty,
  input  logic [7:0]  fifo_rdata,
  output logic        fifo_rinc,
  input  logic        ft_busy,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_code,
  output logic [15:0] cmd_payload,
  output logic        err_unknown,
  output logic        err_timeout,
  output logic [7:0]  err_count
);

  localparam logic [CNT_W-1:0] TCNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [7:0]       op_reg, msb_reg, lsb_reg;
  logic [CNT_W-1:0] tcnt_reg;
  logic             cmd_valid_reg;
  logic             tcnt_clr, tcnt_inc, clr_payload;
  logic             byte_avail, timeout_hit;
  op_class_t        op_class;

  assign byte_avail  = !fifo_rempty && !ft_busy;
  assign timeout_hit = (tcnt_reg == TCNT_LAST);
  assign op_class    = classify_op(op_reg);

  always_comb begin
    state_next  = state_reg;
    fifo_rinc   = 1'b0;
    err_unknown = 1'b0;
    err_timeout = 1'b0;
    tcnt_clr    = 1'b0;
    tcnt_inc    = 1'b0;
    clr_payload = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (byte_avail) state_next = ST_FETCH_OP;
      end
      ST_FETCH_OP: begin
        fifo_rinc  = 1'b1;
        state_next = ST_DECODE;
      end
      ST_DECODE: begin
        case (op_class)
          OP_NO_PAYLOAD: begin
            clr_payload = 1'b1;
            state_next  = ST_OUT;
          end
          OP_TWO_PAYLOAD: begin
            tcnt_clr   = 1'b1;
            state_next = ST_WAIT_MSB;
          end
          default: begin
            err_unknown = 1'b1;
            state_next  = ST_IDLE;
          end
        endcase
      end
      ST_WAIT_MSB, ST_WAIT_LSB: begin
        // A byte arriving on the last allowed cycle still wins over the timeout.
        if (byte_avail) begin
          state_next = (state_reg == ST_WAIT_MSB) ? ST_FETCH_MSB : ST_FETCH_LSB;
        end else if (timeout_hit) begin
          err_timeout = 1'b1;
          tcnt_clr    = 1'b1;
          state_next  = ST_IDLE;
        end else begin
          tcnt_inc = 1'b1;
        end
      end
      ST_FETCH_MSB: begin
        fifo_rinc  = 1'b1;
        tcnt_clr   = 1'b1;
        state_next = ST_WAIT_LSB;
      end
      ST_FETCH_LSB: begin
        fifo_rinc  = 1'b1;
        state_next = ST_OUT;
      end
      ST_OUT: begin
        if (cmd_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      op_reg        <= 8'h00;
      msb_reg       <= 8'h00;
      lsb_reg       <= 8'h00;
      tcnt_reg      <= '0;
      cmd_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cmd_valid_reg <= (state_next == ST_OUT);
      if (state_reg == ST_FETCH_OP)  op_reg  <= fifo_rdata;
      if (state_reg == ST_FETCH_MSB) msb_reg <= fifo_rdata;
      if (state_reg == ST_FETCH_LSB) lsb_reg <= fifo_rdata;
      if (clr_payload) begin
        msb_reg <= 8'h00;
        lsb_reg <= 8'h00;
      end
      if (tcnt_clr)      tcnt_reg <= '0;
      else if (tcnt_inc) tcnt_reg <= tcnt_reg + 1'b1;
    end
  end

  rx_cmd_decoder_sat_counter u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_unknown | err_timeout),
    .count (err_count)
  );

  assign cmd_valid   = cmd_valid_reg;
  assign cmd_code    = op_reg;
  assign cmd_payload = {msb_reg, lsb_reg};

endmodule
